usb_utmi_tx: RTL

- UTMI transmit engine: the send direction of the sniffer's ULPI/UTMI receive path.
- Takes a byte stream from the SoC (first byte = PID, remaining bytes = payload), serialises it onto the UTMI transmit interface (utmi_data_out / utmi_txvalid / utmi_txready) of ulpi_wrapper, in the USB clock domain.
- Generates the PID check nibble itself; appends CRC16 to data packets.
- Enforces a minimum inter-packet gap between packets.

---
 rtl/usb_defs.sv | 45 ++++
 rtl/usb_crc16.sv | 32 +++
 rtl/usb_utmi_tx.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/usb_defs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : usb_defs                                                   |
// | Purpose : Shared USB definitions: PID codes, CRC16 constants and the |
// |           UTMI transmit engine state encoding.                       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package usb_defs;

  // Token PIDs
  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;
  // Data PIDs
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_DATA2 = 4'h7;
  localparam logic [3:0] PID_MDATA = 4'hF;
  // Handshake PIDs
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  // USB CRC16, reflected form (bit 0 of each byte is shifted in first)
  localparam logic [15:0] CRC16_POLY = 16'hA001;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_CRC_LO = 3'd2,
    ST_CRC_HI = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_GAP    = 3'd5,
    ST_FLUSH  = 3'd6
  } tx_state_t;

  // Every data PID (DATA0/1/2, MDATA) has its two low bits set
  function automatic logic is_data_pid(input logic [3:0] pid);
    return (pid[1:0] == 2'b11);
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_crc16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : usb_crc16                                                  |
// | Purpose : Combinational byte-wide USB CRC16 update, LSB first.       |
// |           Shared between transmit generation and receive checking.   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module usb_crc16
  import usb_defs::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  logic [15:0] crc_acc;

  // Fold the eight data bits into the register one at a time, bit 0 first
  always_comb begin
    crc_acc = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_acc[0] ^ data_in[i]) begin
        crc_acc = (crc_acc >> 1) ^ CRC16_POLY;
      end else begin
        crc_acc = crc_acc >> 1;
      end
    end
    crc_out = crc_acc;
  end

endmodule
`default_nettype wire

// File: rtl/usb_utmi_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : usb_utmi_tx                                                |
// | Purpose : UTMI transmit engine. Serialises PID + payload bytes onto  |
// |           the UTMI TX interface, builds the PID check nibble, appends|
// |           CRC16 on data packets and enforces an inter-packet gap.    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module usb_utmi_tx
  import usb_defs::*;
#(
  parameter int IPG_CYCLES = 8   // must be at least 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inport_valid_i,
  input  logic [7:0] inport_data_i,
  input  logic       inport_last_i,
  output logic       inport_accept_o,
  output logic [7:0] utmi_data_o,
  output logic       utmi_txvalid_o,
  input  logic       utmi_txready_i,
  output logic       busy_o,
  output logic       sent_o,
  output logic       underrun_o
);

  localparam int GAP_W = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IPG_CYCLES - 1);

  tx_state_t        state;
  logic [15:0]      crc;
  logic [15:0]      crc_next;
  logic [GAP_W-1:0] gap_cnt;
  logic             pkt_is_data;
  logic             txvalid;
  logic [7:0]       data_out;
  logic             underrun;

  logic             reg_free;
  logic             consume;
  logic             accept_raw;
  logic [3:0]       pid;

  // The output register doubles as the holding register: it can take a
  // new byte when empty or when the PHY is taking the current one.
  assign reg_free = ~txvalid | utmi_txready_i;
  assign consume  = txvalid & utmi_txready_i;
  assign pid      = inport_data_i[3:0];

  usb_crc16 u_crc16 (
    .crc_in  (crc),
    .data_in (inport_data_i),
    .crc_out (crc_next)
  );

  // Input acceptance per state; held low while reset is applied
  always_comb begin
    accept_raw = 1'b0;
    case (state)
      ST_IDLE:  accept_raw = 1'b1;
      ST_DATA:  accept_raw = reg_free;
      ST_FLUSH: accept_raw = 1'b1;
      default:  accept_raw = 1'b0;
    endcase
  end

  assign inport_accept_o = accept_raw & ~rst_i;
  assign utmi_data_o     = data_out;
  assign utmi_txvalid_o  = txvalid;
  assign underrun_o      = underrun;
  assign busy_o          = (state != ST_IDLE);
  assign sent_o          = (state == ST_DRAIN) & consume;

  // Transmit state machine with registered UTMI outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      crc         <= CRC16_INIT;
      gap_cnt     <= '0;
      pkt_is_data <= 1'b0;
      txvalid     <= 1'b0;
      data_out    <= 8'h00;
      underrun    <= 1'b0;
    end else begin
      underrun <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (inport_valid_i) begin
            data_out    <= {~pid, pid};
            txvalid     <= 1'b1;
            crc         <= CRC16_INIT;
            pkt_is_data <= is_data_pid(pid);
            if (inport_last_i) begin
              state <= is_data_pid(pid) ? ST_CRC_LO : ST_DRAIN;
            end else begin
              state <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (inport_valid_i && reg_free) begin
            data_out <= inport_data_i;
            txvalid  <= 1'b1;
            if (pkt_is_data) begin
              crc <= crc_next;
            end
            if (inport_last_i) begin
              state <= pkt_is_data ? ST_CRC_LO : ST_DRAIN;
            end
          end else if (consume) begin
            // Byte left the register with nothing to replace it: abort
            txvalid  <= 1'b0;
            underrun <= 1'b1;
            state    <= ST_FLUSH;
          end
        end

        ST_CRC_LO: begin
          if (reg_free) begin
            data_out <= ~crc[7:0];
            txvalid  <= 1'b1;
            state    <= ST_CRC_HI;
          end
        end

        ST_CRC_HI: begin
          if (reg_free) begin
            data_out <= ~crc[15:8];
            txvalid  <= 1'b1;
            state    <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (consume) begin
            txvalid <= 1'b0;
            gap_cnt <= GAP_LOAD;
            state   <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (gap_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        ST_FLUSH: begin
          if (inport_valid_i && inport_last_i) begin
            gap_cnt <= GAP_LOAD;
            state   <= ST_GAP;
          end
        end

        default: begin
          txvalid <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
